// File: rtl/uart_receiver.sv
// 8N1 UART receive path: 2-flop synchroniser, start-bit validation at mid-bit,
// data/stop sampling every comp+1 cycles, valid/ack handshake, frame/overrun flags.
module uart_receiver (
  input  logic        clk,
  input  logic        reset,
  input  logic        rec_en,
  input  logic [15:0] comp,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        frame_err,
  output logic        ovr_err
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StReceive,
    StStop,
    StBreak
  } state_e;

  state_e      r_state;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic [15:0] r_counter;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_int_reg;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;
  logic        r_ovr_err;

  state_e      w_state_nxt;
  logic [15:0] w_counter_nxt;
  logic [2:0]  w_bit_cnt_nxt;
  logic [7:0]  w_int_reg_nxt;
  logic [7:0]  w_rx_data_nxt;
  logic        w_rx_valid_nxt;
  logic        w_frame_err_nxt;
  logic        w_ovr_err_nxt;
  logic [15:0] w_half;
  logic [15:0] w_cnt_inc;
  logic        w_bit_done;

  assign w_half     = {1'b0, comp[15:1]};
  assign w_cnt_inc  = r_counter + 16'd1;
  assign w_bit_done = (r_counter >= comp);

  always_comb begin
    w_state_nxt     = r_state;
    w_counter_nxt   = r_counter;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_int_reg_nxt   = r_int_reg;
    w_rx_data_nxt   = r_rx_data;
    // Ack clears the pending byte unless a completion overrides it below.
    w_rx_valid_nxt  = r_rx_valid & ~rx_ack;
    w_frame_err_nxt = 1'b0;
    w_ovr_err_nxt   = 1'b0;

    if (!rec_en) begin
      w_state_nxt   = StIdle;
      w_counter_nxt = 16'd0;
      w_bit_cnt_nxt = 3'd0;
      w_int_reg_nxt = 8'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!r_rx_s2) begin
            w_state_nxt   = StStart;
            w_counter_nxt = 16'd0;
          end
        end

        StStart: begin
          if (r_counter >= w_half) begin
            w_counter_nxt = 16'd0;
            if (!r_rx_s2) begin
              w_state_nxt   = StReceive;
              w_bit_cnt_nxt = 3'd0;
            end else begin
              w_state_nxt = StIdle;
            end
          end else begin
            w_counter_nxt = w_cnt_inc;
          end
        end

        StReceive: begin
          if (w_bit_done) begin
            w_int_reg_nxt[r_bit_cnt] = r_rx_s2;
            w_counter_nxt            = 16'd0;
            w_bit_cnt_nxt            = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt = StStop;
            end
          end else begin
            w_counter_nxt = w_cnt_inc;
          end
        end

        StStop: begin
          if (w_bit_done) begin
            w_counter_nxt   = 16'd0;
            w_rx_data_nxt   = r_int_reg;
            w_rx_valid_nxt  = 1'b1;
            w_frame_err_nxt = ~r_rx_s2;
            w_ovr_err_nxt   = r_rx_valid & ~rx_ack;
            // A low stop bit parks in StBreak so a held-low line cannot retrigger.
            w_state_nxt     = r_rx_s2 ? StIdle : StBreak;
          end else begin
            w_counter_nxt = w_cnt_inc;
          end
        end

        StBreak: begin
          if (r_rx_s2) begin
            w_state_nxt = StIdle;
          end
        end

        default: begin
          w_state_nxt   = StIdle;
          w_counter_nxt = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_counter   <= 16'd0;
      r_bit_cnt   <= 3'd0;
      r_int_reg   <= 8'd0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_ovr_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_counter   <= w_counter_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_int_reg   <= w_int_reg_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_ovr_err   <= w_ovr_err_nxt;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign ovr_err   = r_ovr_err;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed scenarios plus random frames, compared every cycle
// against a frame-level model that predicts completion edges arithmetically.
module tb_uart_receiver;

  logic        clk;
  logic        reset;
  logic        rec_en;
  logic [15:0] comp;
  logic        uart_rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        frame_err;
  logic        ovr_err;

  uart_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .rec_en    (rec_en),
    .comp      (comp),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .ovr_err   (ovr_err)
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        ferr;
  } ev_t;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  ev_t         exp_q[$];
  int          head  = 0;
  logic        exp_valid = 1'b0;
  logic [7:0]  exp_data  = 8'h00;
  logic        exp_ferr  = 1'b0;
  logic        exp_ovr   = 1'b0;
  bit          ack_en    = 1'b0;
  int unsigned ack_at    = 0;
  int unsigned last_e0   = 0;
  int unsigned last_rise = 0;
  logic        prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Frame-level model: a byte lands exactly at edge0 + 3 + h + 9*T.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      exp_ferr  = 1'b0;
      exp_ovr   = 1'b0;
      head      = exp_q.size();
    end else begin
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      if (head < exp_q.size() && exp_q[head].cyc == cyc + 1) begin
        exp_ovr   = exp_valid && !rx_ack;
        exp_ferr  = exp_q[head].ferr;
        exp_data  = exp_q[head].data;
        exp_valid = 1'b1;
        head++;
      end else if (rx_ack) begin
        exp_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("rx_valid", {31'd0, rx_valid}, {31'd0, exp_valid});
    check("rx_data", {24'd0, rx_data}, {24'd0, exp_data});
    check("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
    check("ovr_err", {31'd0, ovr_err}, {31'd0, exp_ovr});
    if (rx_valid && !prev_valid) last_rise = cyc;
    prev_valid = rx_valid;
  end

  // Ack driver: random acks of pending bytes, or one forced ack sampled at edge ack_at.
  initial begin
    rx_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rx_ack = ((cyc + 1) == ack_at) || (ack_en && rx_valid && ($urandom_range(0, 2) == 0));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int unsigned done_offset();
    return 3 + int'(comp >> 1) + 9 * (int'(comp) + 1);
  endfunction

  task automatic send_frame(input logic [7:0] d, input int stop_low, input bit expect_rx);
    int  t;
    ev_t ev;
    t       = int'(comp) + 1;
    last_e0 = cyc + 1;
    if (expect_rx) begin
      ev.cyc  = last_e0 + done_offset();
      ev.data = d;
      ev.ferr = (stop_low != 0);
      exp_q.push_back(ev);
    end
    uart_rx = 1'b0;
    idle(t);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      idle(t);
    end
    if (stop_low > 0) begin
      uart_rx = 1'b0;
      idle(stop_low * t);
    end
    uart_rx = 1'b1;
    idle(t);
  endtask

  task automatic set_comp(input int c);
    rec_en = 1'b0;
    idle(1);
    comp = 16'(c);
    idle(2);
    rec_en = 1'b1;
    idle(2);
  endtask

  initial begin
    int t;
    int gap;
    int stop_low;
    reset   = 1'b1;
    rec_en  = 1'b0;
    comp    = 16'd15;
    uart_rx = 1'b1;
    @(posedge clk);
    #1;
    check("reset_data", {24'd0, rx_data}, 32'h0);
    check("reset_valid", {31'd0, rx_valid}, 32'h0);
    idle(2);
    reset  = 1'b0;
    rec_en = 1'b1;
    idle(3);

    // Single byte with exact completion edge, then ack.
    ack_en = 1'b0;
    send_frame(8'hA5, 0, 1'b1);
    check("a5_edge", last_rise, last_e0 + 154);
    idle(3);
    ack_at = cyc + 2;
    idle(4);

    // Back-to-back frames, acked promptly.
    ack_en = 1'b1;
    send_frame(8'h00, 0, 1'b1);
    send_frame(8'hFF, 0, 1'b1);
    send_frame(8'h3C, 0, 1'b1);
    idle(32);

    // Overrun, then ack coinciding with completion.
    ack_en = 1'b0;
    send_frame(8'h11, 0, 1'b1);
    send_frame(8'h22, 0, 1'b1);
    ack_at = cyc + 1 + done_offset();
    send_frame(8'h33, 0, 1'b1);
    ack_en = 1'b1;
    idle(8);
    ack_en = 1'b0;
    ack_at = cyc + 2;
    idle(4);

    // Framing error with a long break, then a clean byte.
    ack_en = 1'b1;
    send_frame(8'h5A, 3, 1'b1);
    send_frame(8'h81, 0, 1'b1);
    idle(20);

    // Short glitch must be rejected.
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(40);

    // Drop enable mid-frame; only the later byte arrives.
    uart_rx = 1'b0;
    idle(16);
    uart_rx = 1'b1;
    idle(16);
    uart_rx = 1'b0;
    idle(32);
    rec_en  = 1'b0;
    uart_rx = 1'b1;
    idle(48);
    rec_en = 1'b1;
    idle(2);
    send_frame(8'hC3, 0, 1'b1);
    idle(20);

    // Asynchronous reset during RECEIVE with an unacked byte pending.
    ack_en = 1'b0;
    send_frame(8'h99, 0, 1'b1);
    uart_rx = 1'b0;
    idle(16);
    uart_rx = 1'b1;
    idle(48);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, rx_valid}, 32'h0);
    check("arst_data", {24'd0, rx_data}, 32'h0);
    check("arst_ferr", {31'd0, frame_err}, 32'h0);
    check("arst_ovr", {31'd0, ovr_err}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);
    ack_en = 1'b1;
    send_frame(8'h7E, 0, 1'b1);
    idle(20);

    // Randomized frames across several baud settings.
    for (int n = 0; n < 24; n++) begin
      if (n % 4 == 0) set_comp($urandom_range(3, 24));
      t        = int'(comp) + 1;
      ack_en   = ($urandom_range(0, 3) != 0);
      stop_low = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      send_frame(8'($urandom), stop_low, 1'b1);
      gap = $urandom_range(0, 2 * t);
      if (gap > 0) idle(gap);
    end
    ack_en = 1'b1;
    idle(60);
    check("all_frames_seen", head, exp_q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
